// File: rtl/aging_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aging_pattern_gen_pkg
// Description : Shared definitions for the aging/burn-in pattern source:
//               pixel-bus bit positions, pattern codes, bar colours and
//               the control FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package aging_pattern_gen_pkg;

    // Pixel bus layout {VS,HS,DE,R,G,B}; the colour-space converter uses the same map
    localparam int c_DP_W     = 27;
    localparam int c_DP_VS    = 26;
    localparam int c_DP_HS    = 25;
    localparam int c_DP_DE    = 24;
    localparam int c_DP_R_LSB = 16;
    localparam int c_DP_G_LSB = 8;
    localparam int c_DP_B_LSB = 0;

    // Pattern codes
    localparam logic [2:0] c_PAT_BLACK   = 3'd0;
    localparam logic [2:0] c_PAT_WHITE   = 3'd1;
    localparam logic [2:0] c_PAT_RED     = 3'd2;
    localparam logic [2:0] c_PAT_GREEN   = 3'd3;
    localparam logic [2:0] c_PAT_BLUE    = 3'd4;
    localparam logic [2:0] c_PAT_BARS    = 3'd5;
    localparam logic [2:0] c_PAT_RAMP    = 3'd6;
    localparam logic [2:0] c_PAT_CHECKER = 3'd7;

    // Colour constants, 24-bit {R,G,B}
    localparam logic [23:0] c_RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] c_RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] c_RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] c_RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] c_RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] c_RGB_RED     = 24'hFF0000;
    localparam logic [23:0] c_RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] c_RGB_BLACK   = 24'h000000;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Colour of each of the eight bars, left to right: W,Y,C,G,M,R,B,K
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = c_RGB_WHITE;
            3'd1:    rgb = c_RGB_YELLOW;
            3'd2:    rgb = c_RGB_CYAN;
            3'd3:    rgb = c_RGB_GREEN;
            3'd4:    rgb = c_RGB_MAGENTA;
            3'd5:    rgb = c_RGB_RED;
            3'd6:    rgb = c_RGB_BLUE;
            default: rgb = c_RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aging_pattern_gen_timing.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster counters for the aging pattern source. Produces
//               h/v position, DE/HS/VS (combinational from the counters)
//               and end-of-line / end-of-frame strobes. Counters run only
//               while i_active is high and sit at (0,0) otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_CNT_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int V_CNT_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_active,
    output logic [H_CNT_W-1:0] o_h_cnt,
    output logic [V_CNT_W-1:0] o_v_cnt,
    output logic               o_de,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_eol,
    output logic               o_eof
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] c_H_LAST     = H_CNT_W'(c_H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] c_H_ACT      = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] c_HS_START   = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] c_HS_END     = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_CNT_W-1:0] c_V_LAST     = V_CNT_W'(c_V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] c_V_ACT      = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] c_VS_START   = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] c_VS_END     = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_CNT_W-1:0] r_h_cnt;
    logic [V_CNT_W-1:0] r_v_cnt;
    logic               w_eol;
    logic               w_eof;

    assign w_eol = (r_h_cnt == c_H_LAST);
    assign w_eof = w_eol && (r_v_cnt == c_V_LAST);

    // Raster counters: h wraps every line, v steps on each h wrap
    always_ff @(posedge clk) begin
        if (rst || !i_active) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_eol) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt = r_h_cnt;
    assign o_v_cnt = r_v_cnt;
    assign o_de    = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign o_hs    = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    assign o_vs    = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
    assign o_eol   = w_eol;
    assign o_eof   = w_eof;

endmodule
`default_nettype wire

// File: rtl/aging_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : aging_pattern_gen
// Description : Pixel source for the colour-space converter. Generates
//               raster timing and one of eight aging/burn-in patterns,
//               optionally auto-cycling every FRAMES_PER_PAT frames.
//               Output bus DPo = {VS,HS,DE,R,G,B}, one cycle behind the
//               raster counters.
//               Optional build macro AGING_PATTERN_BORDER_EN: forces a
//               one-pixel white border around the active area.
// Revision    : 1.0 - initial release
// ============================================================================
module aging_pattern_gen #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int FRAMES_PER_PAT = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        auto_cycle,
    input  logic [2:0]  pat_sel,
    output logic [26:0] DPo,
    output logic        frame_start,
    output logic [2:0]  pat_cur
);

    import aging_pattern_gen_pkg::*;

    localparam int c_H_CNT_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int c_V_CNT_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    // Bar geometry: eight bars of H_ACTIVE/8, the last one takes the remainder
    localparam int c_BAR_W  = H_ACTIVE / 8;
    localparam int c_BAR_PW = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;
    localparam logic [c_BAR_PW-1:0] c_BAR_LAST = c_BAR_PW'(c_BAR_W - 1);

    localparam int c_FC_W = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
    localparam logic [c_FC_W-1:0] c_FC_LAST = c_FC_W'(FRAMES_PER_PAT - 1);

    // ------------------------------------------------------------------
    // Raster timing
    // ------------------------------------------------------------------
    logic [c_H_CNT_W-1:0] w_h_cnt;
    logic [c_V_CNT_W-1:0] w_v_cnt;
    logic                 w_de;
    logic                 w_hs;
    logic                 w_vs;
    logic                 w_eol;
    logic                 w_eof;
    logic                 w_active;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_CNT_W  (c_H_CNT_W),
        .V_CNT_W  (c_V_CNT_W)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .i_active (w_active),
        .o_h_cnt  (w_h_cnt),
        .o_v_cnt  (w_v_cnt),
        .o_de     (w_de),
        .o_hs     (w_hs),
        .o_vs     (w_vs),
        .o_eol    (w_eol),
        .o_eof    (w_eof)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_start;   // IDLE->RUN: counters begin at (0,0) next cycle
    logic   w_wrap;    // frame wraps to (0,0) and another frame follows

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; a frame in progress always completes before IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                w_wrap = w_eof;
                if (!en) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_wrap      = w_eof;
                end else if (w_eof) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_active = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Pattern latch and auto-cycle
    // ------------------------------------------------------------------
    logic [2:0]        r_pat;         // pattern for the frame at the counters
    logic [c_FC_W-1:0] r_frame_cnt;
    logic              r_auto_armed;  // auto-cycle was on for the frame just ended

    // Pattern only changes where a new frame begins; the first frame after
    // auto_cycle rises re-arms the frame count instead of stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat        <= c_PAT_BLACK;
            r_frame_cnt  <= '0;
            r_auto_armed <= 1'b0;
        end else if (w_start) begin
            r_pat        <= auto_cycle ? r_pat : pat_sel;
            r_frame_cnt  <= '0;
            r_auto_armed <= auto_cycle;
        end else if (w_wrap) begin
            if (!auto_cycle) begin
                r_pat        <= pat_sel;
                r_frame_cnt  <= '0;
                r_auto_armed <= 1'b0;
            end else if (!r_auto_armed) begin
                r_frame_cnt  <= '0;
                r_auto_armed <= 1'b1;
            end else if (r_frame_cnt == c_FC_LAST) begin
                r_frame_cnt <= '0;
                r_pat       <= r_pat + 3'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Colour-bar position tracker (replaces an x / bar-width divide)
    // ------------------------------------------------------------------
    logic [2:0]          r_bar_idx;
    logic [c_BAR_PW-1:0] r_bar_pos;

    // Follows h_cnt: restarts with each line, bar 7 holds to line end
    always_ff @(posedge clk) begin
        if (rst || !w_active || w_eol) begin
            r_bar_idx <= 3'd0;
            r_bar_pos <= '0;
        end else if (r_bar_idx != 3'd7) begin
            if (r_bar_pos == c_BAR_LAST) begin
                r_bar_pos <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_pos <= r_bar_pos + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel mux
    // ------------------------------------------------------------------
    logic [7:0]  w_x8;
    logic        w_chk;
    logic [23:0] w_rgb;

    assign w_x8  = 8'(w_h_cnt);
    assign w_chk = 1'(w_h_cnt >> 5) ^ 1'(w_v_cnt >> 5);

`ifdef AGING_PATTERN_BORDER_EN
    localparam logic [c_H_CNT_W-1:0] c_X_LAST = c_H_CNT_W'(H_ACTIVE - 1);
    localparam logic [c_V_CNT_W-1:0] c_Y_LAST = c_V_CNT_W'(V_ACTIVE - 1);
    logic w_border;
    assign w_border = (w_h_cnt == '0) || (w_h_cnt == c_X_LAST) ||
                      (w_v_cnt == '0) || (w_v_cnt == c_Y_LAST);
`endif

    // Select pattern colour; blanking always carries black
    always_comb begin
        w_rgb = c_RGB_BLACK;
        case (r_pat)
            c_PAT_BLACK:   w_rgb = c_RGB_BLACK;
            c_PAT_WHITE:   w_rgb = c_RGB_WHITE;
            c_PAT_RED:     w_rgb = c_RGB_RED;
            c_PAT_GREEN:   w_rgb = c_RGB_GREEN;
            c_PAT_BLUE:    w_rgb = c_RGB_BLUE;
            c_PAT_BARS:    w_rgb = bar_colour(r_bar_idx);
            c_PAT_RAMP:    w_rgb = {w_x8, w_x8, w_x8};
            c_PAT_CHECKER: w_rgb = w_chk ? c_RGB_WHITE : c_RGB_BLACK;
            default:       w_rgb = c_RGB_BLACK;
        endcase
`ifdef AGING_PATTERN_BORDER_EN
        if (w_border) begin
            w_rgb = c_RGB_WHITE;
        end
`endif
        if (!w_de) begin
            w_rgb = c_RGB_BLACK;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [c_DP_W-1:0] r_dpo;
    logic              r_frame_start;
    logic [2:0]        r_pat_cur;

    // Register the pixel; pat_cur trails r_pat so it changes with frame_start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dpo         <= '0;
            r_frame_start <= 1'b0;
            r_pat_cur     <= c_PAT_BLACK;
        end else begin
            r_dpo         <= w_active ? {w_vs, w_hs, w_de, w_rgb} : '0;
            r_frame_start <= w_active && (w_h_cnt == '0) && (w_v_cnt == '0);
            r_pat_cur     <= r_pat;
        end
    end

    assign DPo         = r_dpo;
    assign frame_start = r_frame_start;
    assign pat_cur     = r_pat_cur;

endmodule
`default_nettype wire

// File: tb/tb_aging_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_aging_pattern_gen
// Description : Directed self-checking bench for aging_pattern_gen using a
//               14x7 raster (H 8/2/2/2, V 4/1/1/1) and 2 frames per pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aging_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        auto_cycle;
    logic [2:0]  pat_sel;
    logic [26:0] DPo;
    logic        frame_start;
    logic [2:0]  pat_cur;

    int n_checks = 0;
    int n_fail   = 0;
    int bh = 0;   // raster position of the pixel currently on DPo
    int bv = 0;

    aging_pattern_gen #(
        .H_ACTIVE       (8),
        .H_FP           (2),
        .H_SYNC         (2),
        .H_BP           (2),
        .V_ACTIVE       (4),
        .V_FP           (1),
        .V_SYNC         (1),
        .V_BP           (1),
        .FRAMES_PER_PAT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .auto_cycle  (auto_cycle),
        .pat_sel     (pat_sel),
        .DPo         (DPo),
        .frame_start (frame_start),
        .pat_cur     (pat_cur)
    );

    always #5 clk = ~clk;

    // Expected pixel bus for raster position (h,v) of pattern p
    function automatic logic [26:0] exp_dpo(input int p, input int h, input int v);
        logic        de, hs, vs;
        logic [23:0] rgb;
        logic [7:0]  x8;
        de = (h < 8) && (v < 4);
        hs = (h >= 10) && (h < 12);
        vs = (v == 5);
        x8 = 8'(h);
        case (p)
            0: rgb = 24'h000000;
            1: rgb = 24'hFFFFFF;
            2: rgb = 24'hFF0000;
            3: rgb = 24'h00FF00;
            4: rgb = 24'h0000FF;
            5: begin
                case (h)
                    0: rgb = 24'hFFFFFF;
                    1: rgb = 24'hFFFF00;
                    2: rgb = 24'h00FFFF;
                    3: rgb = 24'h00FF00;
                    4: rgb = 24'hFF00FF;
                    5: rgb = 24'hFF0000;
                    6: rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            6: rgb = {x8, x8, x8};
            default: rgb = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        endcase
`ifdef AGING_PATTERN_BORDER_EN
        if (h == 0 || h == 7 || v == 0 || v == 3) rgb = 24'hFFFFFF;
`endif
        if (!de) rgb = 24'h000000;
        return {vs, hs, de, rgb};
    endfunction

    // Advance one clock and the bench's view of the raster position
    task automatic step();
        @(posedge clk);
        #1;
        if (bh == 13) begin
            bh = 0;
            bv = (bv == 6) ? 0 : bv + 1;
        end else begin
            bh = bh + 1;
        end
    endtask

    task automatic test_reset();
        logic [30:0] got;
        logic [30:0] want;
        rst = 1'b1; en = 1'b1; auto_cycle = 1'b0; pat_sel = 3'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {frame_start, pat_cur, DPo};
            n_checks++;
            if (got !== 31'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h want 0", got);
            end
        end
        rst = 1'b0;
        step();
        got = {frame_start, pat_cur, DPo};
        want = {1'b0, 3'd0, 27'd0};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_first_cycle: got %h want %h", got, want);
        end
        step();
        bh = 0; bv = 0;
        got = {frame_start, pat_cur, DPo};
        want = {1'b1, 3'd5, 27'h1FFFFFF};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_first_pixel: got %h want %h", got, want);
        end
    endtask

    task automatic test_bars();
        logic [30:0] got;
        logic [30:0] want;
        for (int i = 0; i < 98; i++) begin
            got  = {frame_start, pat_cur, DPo};
            want = {(bh == 0 && bv == 0), 3'd5, exp_dpo(5, bh, bv)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL bars h=%0d v=%0d: got %h want %h", bh, bv, got, want);
            end
            step();
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_period: frame_start=%b want 1 after 98 cycles", frame_start);
        end
    endtask

    task automatic test_pat_switch();
        logic [30:0] got;
        logic [30:0] want;
        int          p;
        pat_sel = 3'd1;
        for (int f = 0; f < 3; f++) begin
            p = (f == 0) ? 5 : f;   // frame already latched as 5, then 1, then 2
            for (int i = 0; i < 98; i++) begin
                got  = {frame_start, pat_cur, DPo};
                want = {(bh == 0 && bv == 0), 3'(p), exp_dpo(p, bh, bv)};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL pat_switch f=%0d h=%0d v=%0d: got %h want %h", f, bh, bv, got, want);
                end
                if (f == 1 && i == 31) pat_sel = 3'd2;  // mid-frame change
                step();
            end
        end
    endtask

    task automatic test_patterns();
        logic [30:0] got;
        logic [30:0] want;
        int          pl[5] = '{0, 3, 4, 6, 7};
        int          prev;
        prev = 2;
        for (int k = 0; k <= 5; k++) begin
            if (k < 5) pat_sel = 3'(pl[k]);
            for (int i = 0; i < 98; i++) begin
                got  = {frame_start, pat_cur, DPo};
                want = {(bh == 0 && bv == 0), 3'(prev), exp_dpo(prev, bh, bv)};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL pattern p=%0d h=%0d v=%0d: got %h want %h", prev, bh, bv, got, want);
                end
                step();
            end
            if (k < 5) prev = pl[k];
        end
    endtask

    task automatic test_auto_cycle();
        logic [30:0] got;
        logic [30:0] want;
        int          ep;
        auto_cycle = 1'b1;
        for (int f = 0; f < 20; f++) begin
            ep = (f < 3) ? 7 : (((f - 3) / 2) % 8);
            if (f == 19) begin
                auto_cycle = 1'b0;
                pat_sel    = 3'd1;
            end
            for (int i = 0; i < 98; i++) begin
                got  = {frame_start, pat_cur, DPo};
                want = {(bh == 0 && bv == 0), 3'(ep), exp_dpo(ep, bh, bv)};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL auto_cycle f=%0d h=%0d v=%0d: got %h want %h", f, bh, bv, got, want);
                end
                step();
            end
        end
    endtask

    task automatic test_drain();
        logic [30:0] got;
        logic [30:0] want;
        for (int i = 0; i < 98; i++) begin
            if (i == 14) en = 1'b0;
            got  = {frame_start, pat_cur, DPo};
            want = {(bh == 0 && bv == 0), 3'd1, exp_dpo(1, bh, bv)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL drain_frame h=%0d v=%0d: got %h want %h", bh, bv, got, want);
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({frame_start, DPo} !== 28'd0) begin
                n_fail++;
                $display("FAIL drain_idle k=%0d: got %h want 0", k, {frame_start, DPo});
            end
            step();
        end
        en = 1'b1;
        step();
        n_checks++;
        if ({frame_start, DPo} !== 28'd0) begin
            n_fail++;
            $display("FAIL restart_gap: got %h want 0", {frame_start, DPo});
        end
        step();
        bh = 0; bv = 0;
        for (int i = 0; i < 98; i++) begin
            if (i == 20) en = 1'b0;
            if (i == 25) en = 1'b1;
            got  = {frame_start, pat_cur, DPo};
            want = {(bh == 0 && bv == 0), 3'd1, exp_dpo(1, bh, bv)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL drain_reraise h=%0d v=%0d: got %h want %h", bh, bv, got, want);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [30:0] got;
        logic [30:0] want;
        for (int i = 0; i < 17; i++) begin
            got  = {frame_start, pat_cur, DPo};
            want = {(bh == 0 && bv == 0), 3'd1, exp_dpo(1, bh, bv)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL pre_reset h=%0d v=%0d: got %h want %h", bh, bv, got, want);
            end
            step();
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({frame_start, pat_cur, DPo} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want 0", {frame_start, pat_cur, DPo});
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({frame_start, DPo} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %h want 0", {frame_start, DPo});
        end
        step();
        bh = 0; bv = 0;
        for (int i = 0; i < 98; i++) begin
            got  = {frame_start, pat_cur, DPo};
            want = {(bh == 0 && bv == 0), 3'd1, exp_dpo(1, bh, bv)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_restart h=%0d v=%0d: got %h want %h", bh, bv, got, want);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_pat_switch();
        test_patterns();
        test_auto_cycle();
        test_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
